// File: rtl/nios2_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_dbg_pkg
// Brief    : Shared types and jdo field positions for the debug-memory master.
// Revision : 1.0
// ============================================================================
package nios2_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

    localparam int ADDR_LSB    = 17;
    localparam int RD_BIT      = 35;
    localparam int CLR_ERR_BIT = 36;
    localparam int WDATA_LSB   = 3;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/nios2_dbg_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : nios2_dbg_timeout_ctr
// Brief    : Per-state cycle counter; tc flags the last allowed cycle.
// Revision : 1.0
// ============================================================================
module nios2_dbg_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tc marks the TIMEOUT-th cycle in the state, so the command is held exactly TIMEOUT cycles
    assign tc = en && (cnt_q == W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/nios2_dbg_ocimem_master.sv
`default_nettype none
// ============================================================================
// Module   : nios2_dbg_ocimem_master
// Brief    : Runs single debug-memory word reads/writes on an Avalon-MM master.
// Revision : 1.0
// ============================================================================
module nios2_dbg_ocimem_master
    import nios2_dbg_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    output logic [AW-1:0] m_address,
    output logic          m_read,
    output logic          m_write,
    output logic [31:0]   m_writedata,
    input  logic          m_waitrequest,
    input  logic [31:0]   m_readdata,
    input  logic          m_readdatavalid
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   mon_q, mon_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          tmo_clr, tmo_en, tmo_tc;
    logic          any_strobe;
    logic          unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37], jdo[WDATA_LSB-1:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[ADDR_LSB +: AW];
                    if (jdo[CLR_ERR_BIT]) err_d = 1'b0;
                    if (jdo[RD_BIT]) begin
                        state_d = ST_RD_REQ;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[WDATA_LSB +: 32];
                    state_d = ST_WR_REQ;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD_REQ;
                    ready_d = 1'b0;
                end
            end
            ST_RD_REQ, ST_RD_WAIT: begin
                // Data may arrive in the acceptance cycle, so RD_REQ can complete directly
                if ((state_q == ST_RD_WAIT || !m_waitrequest) && m_readdatavalid) begin
                    mon_d   = m_readdata;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_RD_REQ && !m_waitrequest) begin
                    state_d = ST_RD_WAIT;
                end else if (tmo_tc) begin
                    mon_d   = TIMEOUT_DATA;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (!m_waitrequest) begin
                    addr_d  = addr_q + AW'(1);
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_tc) begin
                    mon_d   = TIMEOUT_DATA;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && any_strobe) err_d = 1'b1;
    end

    always_comb begin
        rd_d    = (state_d == ST_RD_REQ);
        wr_d    = (state_d == ST_WR_REQ);
        tmo_clr = (state_d != ST_IDLE) && (state_d != state_q);
        tmo_en  = (state_q != ST_IDLE);
    end

    nios2_dbg_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
    assign m_address     = addr_q;
    assign m_read        = rd_q;
    assign m_write       = wr_q;
    assign m_writedata   = wdata_q;

endmodule
`default_nettype wire
